matvec_seq_accelerator: RTL and testbench

- Memory-mapped row-vector × matrix accelerator (y = A·B) on the CPU native memory bus (mem_valid/mem_ready handshake).
- Next generation of the combinational chunk multiplier, with these additions:
  - sequential engine: S parallel MAC lanes, one row index per cycle;
  - control/status register with start, busy and done;
  - signed or unsigned arithmetic;
  - optional accumulation across chunks;
  - registered results, one 32-bit word per element.

---
 rtl/matvec_pkg.sv | 36 +++
 rtl/matvec_mac_lane.sv | 48 ++++
 rtl/matvec_seq_accelerator.sv | 191 +++++++++++++++++++
 tb/tb_matvec_seq_accelerator.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared constants and types for the sequential row-vector x matrix accelerator.
// Region offsets are byte offsets from the mapped window base.
package matvec_pkg;

    localparam logic [31:0] OFF_CTRL = 32'h0000_0000;
    localparam logic [31:0] OFF_A    = 32'h0000_1000;
    localparam logic [31:0] OFF_B    = 32'h0000_2000;
    localparam logic [31:0] OFF_Y    = 32'h0000_3000;
    localparam logic [31:0] OFF_SPAN = 32'h0000_4000;

    // CTRL write bits
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SIGNED = 1;
    localparam int unsigned CTRL_ACCUM  = 2;
    // CTRL read-only status bits
    localparam int unsigned CTRL_BUSY   = 0;
    localparam int unsigned CTRL_DONE   = 3;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        RegCtrl,
        RegA,
        RegB,
        RegY
    } region_e;

    // The four regions are 4 KiB apart, so bits [13:12] of the offset select one.
    function automatic region_e region_of(logic [31:0] off);
        return region_e'(off[13:12]);
    endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// One multiply-accumulate lane: acc += a*b (signed or unsigned), wrapping at RESULT_WIDTH.
// Clear has priority over enable.
module matvec_mac_lane
    import matvec_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    signed_i,
    input  logic [INPUT_WIDTH-1:0]  a_i,
    input  logic [INPUT_WIDTH-1:0]  b_i,
    output logic [RESULT_WIDTH-1:0] acc_o
);

    logic signed [INPUT_WIDTH:0]    a_s;
    logic signed [INPUT_WIDTH:0]    b_s;
    logic signed [RESULT_WIDTH-1:0] a_w;
    logic signed [RESULT_WIDTH-1:0] b_w;
    logic signed [RESULT_WIDTH-1:0] prod;
    logic [RESULT_WIDTH-1:0]        acc_q;

    // Extending both operands to RESULT_WIDTH before multiplying yields the exact
    // 2*INPUT_WIDTH product already extended and reduced modulo 2^RESULT_WIDTH.
    always_comb begin
        a_s  = {signed_i & a_i[INPUT_WIDTH-1], a_i};
        b_s  = {signed_i & b_i[INPUT_WIDTH-1], b_i};
        a_w  = RESULT_WIDTH'(a_s);
        b_w  = RESULT_WIDTH'(b_s);
        prod = a_w * b_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + prod;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matvec_seq_accelerator.sv
// Memory-mapped y = A*B engine: bus decode, operand storage, control FSM and S MAC lanes
// that consume one row of B per cycle.
module matvec_seq_accelerator
    import matvec_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0110_0000,
    parameter int unsigned R            = 8,
    parameter int unsigned S            = 8,
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata
);

    localparam int unsigned AW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned BW = (R * S > 1) ? $clog2(R * S) : 1;

    logic [INPUT_WIDTH-1:0]  a_q [R];
    logic [INPUT_WIDTH-1:0]  b_q [R*S];
    logic [RESULT_WIDTH-1:0] y_acc [S];

    state_e      state_q;
    logic [AW-1:0] idx_q;
    logic        signed_q;
    logic        accum_q;
    logic        done_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;

    logic [31:0]   off;
    logic [31:0]   widx;
    region_e       region;
    logic          in_win;
    logic          hit;
    logic          accept;
    logic          wr;
    logic          ctrl_wr;
    logic          busy;
    logic          start_go;
    logic          lane_clr;
    logic [AW-1:0] a_sel;
    logic [BW-1:0] b_sel;
    logic [SW-1:0] y_sel;
    logic [31:0]   rdata_d;

    function automatic logic [INPUT_WIDTH-1:0] merge_bytes(logic [INPUT_WIDTH-1:0] old,
                                                           logic [31:0] wdata,
                                                           logic [3:0] strb);
        logic [31:0] w;
        w = 32'(old);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        return w[INPUT_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] ext_op(logic [INPUT_WIDTH-1:0] v, logic sgn);
        logic [31:0] r;
        r = {32{sgn & v[INPUT_WIDTH-1]}};
        r[INPUT_WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] ext_res(logic [RESULT_WIDTH-1:0] v, logic sgn);
        logic [31:0] r;
        r = {32{sgn & v[RESULT_WIDTH-1]}};
        r[RESULT_WIDTH-1:0] = v;
        return r;
    endfunction

    // Address decode; only in-range element indices of each region are acknowledged.
    always_comb begin
        off    = mem_addr - ADDR_BASE;
        in_win = (mem_addr >= ADDR_BASE) && (off < OFF_SPAN);
        region = region_of(off);
        widx   = {22'd0, off[11:2]};
        a_sel  = widx[AW-1:0];
        b_sel  = widx[BW-1:0];
        y_sel  = widx[SW-1:0];
        case (region)
            RegCtrl: hit = (widx == 32'd0);
            RegA:    hit = (widx < R);
            RegB:    hit = (widx < R * S);
            default: hit = (widx < S);
        endcase
        accept   = mem_valid && !mem_ready_q && in_win && hit;
        wr       = accept && (mem_wstrb != 4'b0000);
        ctrl_wr  = wr && (region == RegCtrl);
        busy     = (state_q == StRun);
        start_go = ctrl_wr && !busy && mem_wdata[CTRL_START];
        lane_clr = start_go && !mem_wdata[CTRL_ACCUM];
    end

    always_comb begin
        rdata_d = '0;
        case (region)
            RegCtrl: begin
                rdata_d[CTRL_BUSY]   = busy;
                rdata_d[CTRL_SIGNED] = signed_q;
                rdata_d[CTRL_ACCUM]  = accum_q;
                rdata_d[CTRL_DONE]   = done_q;
            end
            RegA:    rdata_d = ext_op(a_q[a_sel], signed_q);
            RegB:    rdata_d = ext_op(b_q[b_sel], signed_q);
            default: rdata_d = ext_res(y_acc[y_sel], signed_q);
        endcase
    end

    // Operands are frozen while a run is in progress so every lane sees a stable matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < R; r++) a_q[r] <= '0;
            for (int i = 0; i < R * S; i++) b_q[i] <= '0;
        end else if (wr && !busy) begin
            if (region == RegA) begin
                a_q[a_sel] <= merge_bytes(a_q[a_sel], mem_wdata, mem_wstrb);
            end else if (region == RegB) begin
                b_q[b_sel] <= merge_bytes(b_q[b_sel], mem_wdata, mem_wstrb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            signed_q    <= 1'b0;
            accum_q     <= 1'b0;
            done_q      <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            mem_ready_q <= accept;
            if (accept) mem_rdata_q <= rdata_d;
            unique case (state_q)
                StIdle: begin
                    if (ctrl_wr) begin
                        signed_q <= mem_wdata[CTRL_SIGNED];
                        accum_q  <= mem_wdata[CTRL_ACCUM];
                    end
                    if (start_go) begin
                        idx_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (idx_q == AW'(R - 1)) begin
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar c = 0; c < S; c++) begin : g_lane
        logic [BW-1:0] sel;
        assign sel = BW'(c * R) + BW'(idx_q);

        matvec_mac_lane #(
            .INPUT_WIDTH  (INPUT_WIDTH),
            .RESULT_WIDTH (RESULT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (lane_clr),
            .en_i     (busy),
            .signed_i (signed_q),
            .a_i      (a_q[idx_q]),
            .b_i      (b_q[sel]),
            .acc_o    (y_acc[c])
        );
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_matvec_seq_accelerator.sv
// Scoreboard bench for matvec_seq_accelerator: expected read data is queued when a request
// is issued and popped when the response arrives.
module tb_matvec_seq_accelerator;

    localparam logic [31:0] BASE = 32'h0110_0000;
    localparam int R = 8;
    localparam int S = 8;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;
    int cyc;
    int last_acc;
    logic [31:0] exp_q[$];

    matvec_seq_accelerator #(
        .ADDR_BASE    (BASE),
        .R            (R),
        .S            (S),
        .INPUT_WIDTH  (8),
        .RESULT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ctrl_a();
        return BASE;
    endfunction
    function automatic logic [31:0] a_addr(int r);
        return BASE + 32'h1000 + 32'(4 * r);
    endfunction
    function automatic logic [31:0] b_addr(int r, int c);
        return BASE + 32'h2000 + 32'(4 * (c * R + r));
    endfunction
    function automatic logic [31:0] y_addr(int c);
        return BASE + 32'h3000 + 32'(4 * c);
    endfunction

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
        logic got;
        got       = 1'b0;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        mem_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        rdata     = mem_rdata;
        last_acc  = cyc;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL bus_ack addr=%h: no mem_ready within 20 cycles", addr);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic [31:0] dummy;
        bus_xfer(addr, data, strb, dummy);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_xfer(addr, 32'h0, 4'b0000, data);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        logic [31:0] d;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus_read(ctrl_a(), d);
            if (d[3] && !d[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: ctrl=%h, run did not finish in 30 polls", d);
        end
    endtask

    task automatic load_all(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < R; r++) bus_write(a_addr(r), 32'(av), 4'hF);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < S; c++) bus_write(b_addr(r, c), 32'(bv), 4'hF);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] e;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       bus_read(ctrl_a(), d);
                1:       bus_read(y_addr(S - 1), d);
                default: bus_read(b_addr(R - 1, S - 1), d);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL reset_val[%0d]: got %h expected %h", k, d, e);
            end
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] d;
        logic [31:0] e;
        bus_write(a_addr(0), 32'h0000_00AB, 4'b0001);
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_pulse: got %b expected 0", mem_ready);
        end
        exp_q.push_back(32'h0000_00AB);
        bus_read(a_addr(0), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL strobe_b0: got %h expected %h", d, e);
        end
        bus_write(a_addr(0), 32'h0000_CD00, 4'b0010);
        exp_q.push_back(32'h0000_00AB);
        bus_read(a_addr(0), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL strobe_b1_merge: got %h expected %h", d, e);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] d;
        logic [31:0] e;
        int t0;
        for (int r = 0; r < R; r++) bus_write(a_addr(r), 32'(r + 1), 4'hF);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < S; c++) bus_write(b_addr(r, c), 32'(c + 1), 4'hF);
        bus_write(ctrl_a(), 32'h1, 4'hF);
        t0 = last_acc;
        // Read accepted on the 8th edge after START still sees the last RUN cycle.
        exp_q.push_back(32'h1);
        wait_cyc(t0 + 7);
        bus_read(ctrl_a(), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL busy_last_cycle: got %h expected %h", d, e);
        end
        exp_q.push_back(32'h8);
        bus_read(ctrl_a(), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL done_after_run: got %h expected %h", d, e);
        end
        for (int c = 0; c < S; c++) exp_q.push_back(32'(36 * (c + 1)));
        for (int c = 0; c < S; c++) begin
            bus_read(y_addr(c), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL unsigned_y[%0d]: got %h expected %h", c, d, e);
            end
        end
    endtask

    task automatic test_busy_protect();
        logic [31:0] d;
        logic [31:0] e;
        int t0;
        bus_write(ctrl_a(), 32'h1, 4'hF);
        t0 = last_acc;
        bus_write(a_addr(0), 32'h55, 4'hF);
        bus_write(ctrl_a(), 32'h1, 4'hF);
        exp_q.push_back(32'h1);
        bus_read(a_addr(0), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL busy_a_write_dropped: got %h expected %h", d, e);
        end
        // First edge after the 8 RUN cycles: must be idle and done, not restarted.
        exp_q.push_back(32'h8);
        wait_cyc(t0 + 8);
        bus_read(ctrl_a(), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL busy_run_length: got %h expected %h", d, e);
        end
        exp_q.push_back(32'd36);
        exp_q.push_back(32'd288);
        for (int k = 0; k < 2; k++) begin
            bus_read(y_addr(k * (S - 1)), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL busy_y[%0d]: got %h expected %h", k * (S - 1), d, e);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] d;
        logic [31:0] e;
        load_all(8'h00, 8'h00);
        bus_write(a_addr(0), 32'hFF, 4'hF);
        bus_write(b_addr(0, 0), 32'h02, 4'hF);
        bus_write(ctrl_a(), 32'h3, 4'hF);
        wait_done();
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       bus_read(y_addr(0), d);
                1:       bus_read(a_addr(0), d);
                default: bus_read(y_addr(1), d);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL signed_rd[%0d]: got %h expected %h", k, d, e);
            end
        end
        // Mode-only update: signed cleared, done stays sticky, result reread unsigned.
        bus_write(ctrl_a(), 32'h0, 4'hF);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_FFFE);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) bus_read(ctrl_a(), d);
            else bus_read(y_addr(0), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL mode_only[%0d]: got %h expected %h", k, d, e);
            end
        end
        bus_write(ctrl_a(), 32'h1, 4'hF);
        wait_done();
        exp_q.push_back(32'h0000_01FE);
        bus_read(y_addr(0), d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_err++;
            $display("FAIL unsigned_ff_x_2: got %h expected %h", d, e);
        end
    endtask

    task automatic test_wrap_accum();
        logic [31:0] d;
        logic [31:0] e;
        load_all(8'hFF, 8'hFF);
        bus_write(ctrl_a(), 32'h1, 4'hF);
        wait_done();
        for (int c = 0; c < S; c++) exp_q.push_back(32'h0000_F008);
        for (int c = 0; c < S; c++) begin
            bus_read(y_addr(c), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL wrap_y[%0d]: got %h expected %h", c, d, e);
            end
        end
        bus_write(ctrl_a(), 32'h5, 4'hF);
        wait_done();
        for (int c = 0; c < S; c++) exp_q.push_back(32'h0000_E010);
        exp_q.push_back(32'h0000_000C);
        for (int c = 0; c <= S; c++) begin
            if (c < S) bus_read(y_addr(c), d);
            else bus_read(ctrl_a(), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL accum_rd[%0d]: got %h expected %h", c, d, e);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        logic [31:0] e;
        logic got;
        int t0;
        bus_write(ctrl_a(), 32'h1, 4'hF);
        t0 = last_acc;
        wait_cyc(t0 + 2);
        rst       = 1'b1;
        mem_addr  = y_addr(0);
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_inflight_ack: got %b expected 0", mem_ready);
        end
        rst       = 1'b0;
        mem_valid = 1'b0;
        exp_q.push_back(32'h0);
        for (int c = 0; c < S; c++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int k = 0; k <= S + 1; k++) begin
            if (k == 0) bus_read(ctrl_a(), d);
            else if (k <= S) bus_read(y_addr(k - 1), d);
            else bus_read(a_addr(0), d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL midrun_reset_rd[%0d]: got %h expected %h", k, d, e);
            end
        end
        got       = 1'b0;
        mem_addr  = y_addr(S);
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) got = 1'b1;
        end
        mem_valid = 1'b0;
        n_cmp++;
        if (got !== 1'b0) begin
            n_err++;
            $display("FAIL bad_addr_ack: got ready=%b expected 0", got);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_acc  = 0;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_byte_strobe();
        test_unsigned();
        test_busy_protect();
        test_signed();
        test_wrap_accum();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
